// File: rtl/io_terminal_port.sv
// Device-side INPR/OUTR terminal port: owns FGI/FGO, accepts rx characters, drains OUTR to tx.
// Optional input FIFO between rx and INPR when IO_RXFIFO_EN is defined.
//
//   state      | meaning
//   S_RX_EMPTY | INPR consumed (FGI=0); base build accepts a new character
//   S_RX_FULL  | INPR holds an unread character (FGI=1)
//   S_TX_IDLE  | OUTR free (FGO=1), waiting for OUT
//   S_TX_SEND  | tx_data/tx_valid presented, waiting for tx_ready
//   S_TX_GAP   | post-handshake idle, counting down before FGO rises
module io_terminal_port #(
    parameter int DW      = 8,
    parameter int TX_GAP  = 2,
    parameter int FIFO_AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          glb_clr,
    input  logic          ld_outr,
    input  logic [DW-1:0] ac_lo,
    input  logic          inp_flag_reset,
    output logic [DW-1:0] inpr,
    output logic          inp_flag,
    output logic          out_flag,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          proto_err
);

    localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (TX_GAP > 0) ? GW'(TX_GAP - 1) : '0;

    typedef enum logic {
        S_RX_EMPTY = 1'b0,
        S_RX_FULL  = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        S_TX_IDLE = 2'd0,
        S_TX_SEND = 2'd1,
        S_TX_GAP  = 2'd2
    } tx_state_t;

    rx_state_t       r_rx_state;
    tx_state_t       r_tx_state;
    logic [DW-1:0]   r_inpr;
    logic [DW-1:0]   r_tx_data;
    logic            r_tx_valid;
    logic            r_out_flag;
    logic            r_proto_err;
    logic [GW-1:0]   r_gap_cnt;

    assign inpr      = r_inpr;
    assign inp_flag  = (r_rx_state == S_RX_FULL);
    assign out_flag  = r_out_flag;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign proto_err = r_proto_err;

`ifdef IO_RXFIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    // Extra MSB distinguishes full from empty once the pointers wrap.
    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign rx_ready = ~w_full;
    assign w_push  = rx_valid & ~w_full & ~glb_clr;
    assign w_pop   = (r_rx_state == S_RX_EMPTY) & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= S_RX_EMPTY;
            r_inpr     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (glb_clr) begin
            r_rx_state <= S_RX_EMPTY;
            r_inpr     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            case (r_rx_state)
                S_RX_EMPTY: begin
                    if (w_pop) begin
                        r_inpr     <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
                        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                        r_rx_state <= S_RX_FULL;
                    end
                end
                S_RX_FULL: begin
                    if (inp_flag_reset) begin
                        r_rx_state <= S_RX_EMPTY;
                    end
                end
                default: r_rx_state <= S_RX_EMPTY;
            endcase
        end
    end
`else
    logic w_unused_fifo_aw;
    assign w_unused_fifo_aw = (FIFO_AW > 0);

    assign rx_ready = (r_rx_state == S_RX_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= S_RX_EMPTY;
            r_inpr     <= '0;
        end else if (glb_clr) begin
            r_rx_state <= S_RX_EMPTY;
            r_inpr     <= '0;
        end else begin
            case (r_rx_state)
                S_RX_EMPTY: begin
                    if (rx_valid) begin
                        r_inpr     <= rx_data;
                        r_rx_state <= S_RX_FULL;
                    end
                end
                S_RX_FULL: begin
                    if (inp_flag_reset) begin
                        r_rx_state <= S_RX_EMPTY;
                    end
                end
                default: r_rx_state <= S_RX_EMPTY;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state  <= S_TX_IDLE;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_out_flag  <= 1'b1;
            r_proto_err <= 1'b0;
            r_gap_cnt   <= '0;
        end else if (glb_clr) begin
            r_tx_state  <= S_TX_IDLE;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_out_flag  <= 1'b1;
            r_proto_err <= 1'b0;
            r_gap_cnt   <= '0;
        end else begin
            // An OUT while OUTR is busy is dropped; only the sticky flag records it.
            if (ld_outr && !r_out_flag) begin
                r_proto_err <= 1'b1;
            end
            case (r_tx_state)
                S_TX_IDLE: begin
                    if (ld_outr) begin
                        r_tx_data  <= ac_lo;
                        r_tx_valid <= 1'b1;
                        r_out_flag <= 1'b0;
                        r_tx_state <= S_TX_SEND;
                    end
                end
                S_TX_SEND: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        if (TX_GAP == 0) begin
                            r_out_flag <= 1'b1;
                            r_tx_state <= S_TX_IDLE;
                        end else begin
                            r_gap_cnt  <= GAP_LOAD;
                            r_tx_state <= S_TX_GAP;
                        end
                    end
                end
                S_TX_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_out_flag <= 1'b1;
                        r_tx_state <= S_TX_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_out_flag <= 1'b1;
                    r_tx_state <= S_TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_terminal_port.sv
// Randomized bench for io_terminal_port against a queue/flag reference model.
module tb_io_terminal_port;

    localparam int DW      = 8;
    localparam int TX_GAP  = 2;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          glb_clr = 1'b0;
    logic          ld_outr = 1'b0;
    logic [DW-1:0] ac_lo = '0;
    logic          inp_flag_reset = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] inpr;
    logic          inp_flag;
    logic          out_flag;
    logic          rx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          proto_err;

    io_terminal_port #(.DW(DW), .TX_GAP(TX_GAP), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .rst_n(rst_n), .glb_clr(glb_clr), .ld_outr(ld_outr), .ac_lo(ac_lo),
        .inp_flag_reset(inp_flag_reset), .inpr(inpr), .inp_flag(inp_flag), .out_flag(out_flag),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [DW-1:0] m_inpr;
    logic          m_flag;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_tx_data;
    logic          m_tx_valid;
    logic          m_out_flag;
    logic          m_perr;
    int            m_gap_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_inpr     = '0;
        m_flag     = 1'b0;
        m_q.delete();
        m_tx_data  = '0;
        m_tx_valid = 1'b0;
        m_out_flag = 1'b1;
        m_perr     = 1'b0;
        m_gap_left = 0;
    endtask

    function automatic logic model_rx_ready();
`ifdef IO_RXFIFO_EN
        return (m_q.size() < DEPTH);
`else
        return !m_flag;
`endif
    endfunction

    // One clock edge of the reference, using the inputs held during the cycle.
    task automatic model_step();
        logic acc;
        if (glb_clr) begin
            model_reset();
            return;
        end
        acc = rx_valid && model_rx_ready();
`ifdef IO_RXFIFO_EN
        if (!m_flag && m_q.size() > 0) begin
            m_inpr = m_q.pop_front();
            m_flag = 1'b1;
        end else if (m_flag && inp_flag_reset) begin
            m_flag = 1'b0;
        end
        if (acc) m_q.push_back(rx_data);
`else
        if (acc) begin
            m_inpr = rx_data;
            m_flag = 1'b1;
        end else if (m_flag && inp_flag_reset) begin
            m_flag = 1'b0;
        end
`endif
        if (ld_outr && !m_out_flag) m_perr = 1'b1;
        if (m_out_flag) begin
            if (ld_outr) begin
                m_tx_data  = ac_lo;
                m_tx_valid = 1'b1;
                m_out_flag = 1'b0;
            end
        end else if (m_tx_valid) begin
            if (tx_ready) begin
                m_tx_valid = 1'b0;
                if (TX_GAP == 0) m_out_flag = 1'b1;
                else m_gap_left = TX_GAP;
            end
        end else begin
            m_gap_left--;
            if (m_gap_left == 0) m_out_flag = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":inpr"},      inpr,      m_inpr);
        check({tag, ":inp_flag"},  inp_flag,  m_flag);
        check({tag, ":out_flag"},  out_flag,  m_out_flag);
        check({tag, ":tx_data"},   tx_data,   m_tx_data);
        check({tag, ":tx_valid"},  tx_valid,  m_tx_valid);
        check({tag, ":proto_err"}, proto_err, m_perr);
        check({tag, ":rx_ready"},  rx_ready,  model_rx_ready());
    endtask

    // Inputs are set at the falling edge; outputs compared at the next falling edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle_inputs();
        glb_clr = 0; ld_outr = 0; inp_flag_reset = 0; rx_valid = 0; tx_ready = 0;
    endtask

    initial begin
        model_reset();
        #12;
        check("T1:inp_flag", inp_flag, 1'b0);
        check("T1:out_flag", out_flag, 1'b1);
        check("T1:tx_valid", tx_valid, 1'b0);
        check("T1:rx_ready", rx_ready, 1'b1);
        check("T1:inpr",     inpr,     8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("T1b");

        rx_data = 8'h41; rx_valid = 1;
        cycle("T2a");
        rx_valid = 0;
`ifndef IO_RXFIFO_EN
        check("T2:inpr", inpr, 8'h41);
        check("T2:inp_flag", inp_flag, 1'b1);
        check("T2:rx_ready", rx_ready, 1'b0);
`endif
        cycle("T2b");
        inp_flag_reset = 1;
        cycle("T2c");
        inp_flag_reset = 0;
        check("T2:inp_flag_clr", inp_flag, 1'b0);
        check("T2:inpr_hold", inpr, 8'h41);

        ac_lo = 8'h5A; ld_outr = 1; tx_ready = 0;
        cycle("T3a");
        ld_outr = 0;
        check("T3:tx_valid", tx_valid, 1'b1);
        check("T3:tx_data", tx_data, 8'h5A);
        check("T3:out_flag_fall", out_flag, 1'b0);
        cycle("T3b");
        ac_lo = 8'hFF; ld_outr = 1;
        cycle("T4a");
        ld_outr = 0;
        check("T4:proto_err", proto_err, 1'b1);
        check("T4:tx_data_hold", tx_data, 8'h5A);
        check("T4:tx_valid_hold", tx_valid, 1'b1);
        tx_ready = 1;
        cycle("T3c");
        tx_ready = 0;
        check("T3:tx_valid_drop", tx_valid, 1'b0);
        check("T3:out_flag_gap1", out_flag, 1'b0);
        cycle("T3d");
        check("T3:out_flag_gap2", out_flag, 1'b0);
        cycle("T3e");
        check("T3:out_flag_rise", out_flag, 1'b1);
        glb_clr = 1;
        cycle("T4b");
        glb_clr = 0;
        check("T4:proto_err_clr", proto_err, 1'b0);
        check("T4:out_flag", out_flag, 1'b1);

`ifdef IO_RXFIFO_EN
        for (int i = 1; i <= 6; i++) begin
            rx_data = 8'(i); rx_valid = 1;
            cycle("T5fill");
            if (!rx_ready) i--;
            if (n_tests > 5000) break;
        end
        rx_valid = 0;
        check("T5:rx_ready_full", rx_ready, 1'b0);
        for (int i = 0; i < 30; i++) begin
            inp_flag_reset = inp_flag;
            if (rx_ready && !rx_valid && rx_data < 8'h06) begin
                rx_data = rx_data + 8'h01; rx_valid = 1;
            end else begin
                rx_valid = 0;
            end
            cycle("T5drain");
        end
        idle_inputs();
`endif

        ac_lo = 8'hC3; ld_outr = 1;
        cycle("T6a");
        ld_outr = 0;
        #2 rst_n = 1'b0;
        #1;
        check("T6:tx_valid_async", tx_valid, 1'b0);
        check("T6:out_flag_async", out_flag, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ac_lo = 8'h3C; ld_outr = 1;
        cycle("T6b");
        ld_outr = 0; tx_ready = 1;
        check("T6:retx_data", tx_data, 8'h3C);
        for (int i = 0; i < 4; i++) cycle("T6c");

        for (int i = 0; i < 3000; i++) begin
            rx_data        = 8'($urandom);
            rx_valid       = ($urandom_range(0, 1) == 1);
            inp_flag_reset = ($urandom_range(0, 9) < 3);
            ac_lo          = 8'($urandom);
            ld_outr        = ($urandom_range(0, 9) < 2);
            tx_ready       = ($urandom_range(0, 9) < 6);
            glb_clr        = ($urandom_range(0, 199) == 0);
            cycle("RND");
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
